gear_shift_scheduler: RTL and testbench
=======================================

// Module: gear_shift_scheduler
// PURPOSE
//  Sequencing controller for the automatic-gearbox FSM: selects gear from vehicle speed,
//  lever mode and kickdown. Runs every change as a timed clutch-open / engage / clutch-close
//  sequence, then enforces a dwell period before the next change.
//  Sits between the ui_in decode and the uo_out drive inside tt_um_fms_MoisesPabloc.
// PARAMETERS
//  NUM_GEARS   5   forward gears, 1..NUM_GEARS; max 6, so code 7 stays free for reverse
//  OPEN_CYC    4   cycles in OPEN (clutch disengaging)
//  ENGAGE_CYC  8   cycles in ENGAGE (gear selector moving, clutch open)
//  CLOSE_CYC   4   cycles in CLOSE (clutch re-engaging)
//  DWELL_CYC   32  minimum cycles after CLOSE before another shift is evaluated
//  HYST        4   speed hysteresis subtracted from downshift thresholds
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous, active-high reset
//  ena            in   1  advance enable; low freezes state, counters and outputs
//  speed_i        in   8  vehicle speed, unsigned
//  mode_i         in   2  lever: 00 park, 01 reverse, 10 neutral, 11 drive
//  kickdown_i     in   1  forced one-step downshift request (level)
//  gear_o         out  3  0 neutral, 1..NUM_GEARS forward, 7 reverse
//  clutch_open_o  out  1  high while in OPEN and ENGAGE
//  shift_busy_o   out  1  high in OPEN, ENGAGE, CLOSE and DWELL
//  state_o        out  3  current state encoding, for debug/uo_out
// BEHAVIOUR
//  Reset (rst=1 at a clk edge, any state, even mid-shift) gives: state IDLE, gear_o=0,
//   clutch_open_o=0, shift_busy_o=0, counter=0, target=0. A reset mid-shift abandons the sequence.
//  States: IDLE=0, RUN=1, OPEN=2, ENGAGE=3, CLOSE=4, DWELL=5 (6,7 illegal -> IDLE next cycle).
//  IDLE: gear_o is 0 (neutral or park).
//   - mode=drive: target=1, go to OPEN.
//   - mode=reverse and speed_i==0: target=7, go to OPEN.
//   - mode=reverse and speed_i!=0: no action.
//  RUN: condition sampled at edge n gives OPEN at edge n+1 (one cycle of latency).
//   Checks in priority order, first match wins:
//   1. mode!=drive while gear forward, or mode!=reverse while gear=7: target=0.
//   2. kickdown_i and 1<gear<=NUM_GEARS: target=gear-1.
//   3. speed_i >= UP_TH[gear-1] and gear<NUM_GEARS: target=gear+1.
//   4. gear>1 and speed_i < UP_TH[gear-2]-HYST: target=gear-1.
//   5. none: stay in RUN.
//   Forward shifts change gear by one step per sequence only.
//  OPEN lasts OPEN_CYC cycles, then ENGAGE.
//   gear_o<=target on the OPEN->ENGAGE edge, so the first ENGAGE cycle shows the new gear.
//  ENGAGE lasts ENGAGE_CYC cycles, then CLOSE. CLOSE lasts CLOSE_CYC cycles, then DWELL.
//  DWELL lasts DWELL_CYC cycles, then RUN; if gear_o==0 it goes to IDLE instead.
//   Exception: a pending kickdown with gear>1 ends DWELL early and goes to OPEN next cycle.
//  Mode and speed changes during OPEN..CLOSE are ignored; a sequence always runs to completion.
//   They are re-evaluated in RUN.
//  Shift time: busy = OPEN_CYC+ENGAGE_CYC+CLOSE_CYC+DWELL_CYC cycles (48 at defaults),
//   unless kickdown cuts DWELL short.
//  One down-counter, width $clog2(max param + 1), loaded on each state entry; the state
//   advances when the counter is 0.
//  Threshold arithmetic: the subtraction UP_TH-HYST saturates at 0, never wraps.
//   Compares are unsigned 8-bit.
//  ena=0: no register changes. ena and rst together: rst wins.
// STRUCTURE
//  Package gearbox_pkg holds:
//   - state enum, gear codes (GEAR_N=0, GEAR_R=7), mode codes
//   - UP_TH[0:4] = {20,40,60,80,100}
//  One sub-module, shift_timer: loadable down-counter with a zero flag, used for all four timed
//   states. The FSM and threshold compare stay in the top module.
// TESTING
//  1. rst=1 for 2 cycles, then release: gear_o=0, state_o=0, busy=0, clutch=0.
//  2. Drive from IDLE: mode=11, speed=0.
//     - clutch_open_o high 12 cycles; gear_o=1 in the 5th cycle after the OPEN entry.
//     - busy for 48 cycles, then state RUN.
//  3. Upshift and hysteresis: in gear 1, set speed=20.
//     - shift to gear 2 completes; then speed=17 causes no downshift (16 is the threshold).
//     - speed=15: downshift to gear 1.
//  4. Kickdown in DWELL: gear 3 in DWELL with 20 cycles left; kickdown_i=1.
//     - OPEN next cycle; gear_o=2 after 4 more cycles.
//  5. Reverse guard and reset mid-shift:
//     - IDLE, mode=01, speed=5: stays IDLE. Then speed=0: gear_o=7.
//     - rst asserted during ENGAGE: IDLE, gear_o=0 next cycle.
//  6. ena=0 for 10 cycles mid-OPEN: state and counter unchanged; the sequence resumes exactly
//     where it stopped.

Source files
------------

// File: rtl/gearbox_pkg.sv
// Shared types, codes and shift thresholds for the automatic gearbox controller.
package gearbox_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_OPEN   = 3'd2,
      ST_ENGAGE = 3'd3,
      ST_CLOSE  = 3'd4,
      ST_DWELL  = 3'd5
   } state_e;

   localparam logic [2:0] GEAR_N = 3'd0;
   localparam logic [2:0] GEAR_R = 3'd7;

   localparam logic [1:0] MODE_PARK  = 2'b00;
   localparam logic [1:0] MODE_REV   = 2'b01;
   localparam logic [1:0] MODE_NEUT  = 2'b10;
   localparam logic [1:0] MODE_DRIVE = 2'b11;

   localparam logic [7:0] UP_TH [0:4] = '{8'd20, 8'd40, 8'd60, 8'd80, 8'd100};

   // Out-of-range indices return 0xFF so no upshift can trigger from them.
   function automatic logic [7:0] up_th(input logic [2:0] idx);
      logic [7:0] t;
      case (idx)
         3'd0:    t = UP_TH[0];
         3'd1:    t = UP_TH[1];
         3'd2:    t = UP_TH[2];
         3'd3:    t = UP_TH[3];
         3'd4:    t = UP_TH[4];
         default: t = 8'hFF;
      endcase
      return t;
   endfunction

   function automatic logic [7:0] down_th(input logic [2:0] idx, input logic [7:0] hyst);
      logic [7:0] t;
      t = up_th(idx);
      return (t > hyst) ? (t - hyst) : 8'd0;
   endfunction

endpackage

// File: rtl/gear_shift_scheduler_shift_timer.sv
// Loadable down-counter with a zero flag; times every phase of a shift sequence.
module shift_timer #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (ena) begin
         if (load)
            cnt <= load_val;
         else if (cnt != '0)
            cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/gear_shift_scheduler.sv
// Gear selection FSM: picks the target gear and runs each change as a timed
// clutch-open / engage / clutch-close / dwell sequence.
module gear_shift_scheduler
   import gearbox_pkg::*;
#(
   parameter int NUM_GEARS  = 5,
   parameter int OPEN_CYC   = 4,
   parameter int ENGAGE_CYC = 8,
   parameter int CLOSE_CYC  = 4,
   parameter int DWELL_CYC  = 32,
   parameter int HYST       = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] speed_i,
   input  logic [1:0] mode_i,
   input  logic       kickdown_i,
   output logic [2:0] gear_o,
   output logic       clutch_open_o,
   output logic       shift_busy_o,
   output logic [2:0] state_o
);

   localparam logic [2:0] IDLE   = ST_IDLE;
   localparam logic [2:0] RUN    = ST_RUN;
   localparam logic [2:0] OPEN   = ST_OPEN;
   localparam logic [2:0] ENGAGE = ST_ENGAGE;
   localparam logic [2:0] CLOSE  = ST_CLOSE;
   localparam logic [2:0] DWELL  = ST_DWELL;

   localparam int MAX_A   = (OPEN_CYC > ENGAGE_CYC) ? OPEN_CYC : ENGAGE_CYC;
   localparam int MAX_B   = (CLOSE_CYC > DWELL_CYC) ? CLOSE_CYC : DWELL_CYC;
   localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW      = $clog2(MAX_CYC + 1);

   localparam logic [2:0] NG     = 3'(NUM_GEARS);
   localparam logic [7:0] HYST_V = 8'(HYST);

   logic [2:0]    state, nxt_state;
   logic [2:0]    gear, target, nxt_target;
   logic          load, tmr_zero;
   logic [CW-1:0] load_val;
   logic          fwd, up_ok, dn_ok, kick_ok, mode_exit;

   // Reverse (7) is above every forward gear, so a single range test covers it.
   assign fwd       = (gear != GEAR_N) && (gear <= NG);
   assign up_ok     = fwd && (gear < NG) && (speed_i >= up_th(3'(gear - 3'd1)));
   assign dn_ok     = fwd && (gear > 3'd1) && (speed_i < down_th(3'(gear - 3'd2), HYST_V));
   assign kick_ok   = kickdown_i && fwd && (gear > 3'd1);
   assign mode_exit = (fwd && mode_i != MODE_DRIVE) || (gear == GEAR_R && mode_i != MODE_REV);

   always_comb begin
      nxt_state  = state;
      nxt_target = target;
      case (state)
         IDLE: begin
            if (mode_i == MODE_DRIVE) begin
               nxt_target = 3'd1;
               nxt_state  = OPEN;
            end else if (mode_i == MODE_REV && speed_i == 8'd0) begin
               nxt_target = GEAR_R;
               nxt_state  = OPEN;
            end
         end
         RUN: begin
            if (mode_exit) begin
               nxt_target = GEAR_N;
               nxt_state  = OPEN;
            end else if (kick_ok || (!up_ok && dn_ok)) begin
               nxt_target = 3'(gear - 3'd1);
               nxt_state  = OPEN;
            end else if (up_ok) begin
               nxt_target = 3'(gear + 3'd1);
               nxt_state  = OPEN;
            end
         end
         OPEN:   if (tmr_zero) nxt_state = ENGAGE;
         ENGAGE: if (tmr_zero) nxt_state = CLOSE;
         CLOSE:  if (tmr_zero) nxt_state = DWELL;
         DWELL: begin
            if (kick_ok) begin
               nxt_target = 3'(gear - 3'd1);
               nxt_state  = OPEN;
            end else if (tmr_zero)
               nxt_state = (gear == GEAR_N) ? IDLE : RUN;
         end
         default: nxt_state = IDLE;
      endcase
   end

   // Counter is reloaded on every state entry; IDLE and RUN park it at zero.
   always_comb begin
      load = (nxt_state != state);
      case (nxt_state)
         OPEN:    load_val = CW'(OPEN_CYC - 1);
         ENGAGE:  load_val = CW'(ENGAGE_CYC - 1);
         CLOSE:   load_val = CW'(CLOSE_CYC - 1);
         DWELL:   load_val = CW'(DWELL_CYC - 1);
         default: load_val = '0;
      endcase
   end

   shift_timer #(.W(CW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .load     (load),
      .load_val (load_val),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         gear   <= GEAR_N;
         target <= GEAR_N;
      end else if (ena) begin
         state  <= nxt_state;
         target <= nxt_target;
         if (state == OPEN && tmr_zero)
            gear <= target;
      end
   end

   assign gear_o        = gear;
   assign state_o       = state;
   assign clutch_open_o = (state == OPEN) || (state == ENGAGE);
   assign shift_busy_o  = (state == OPEN) || (state == ENGAGE) ||
                          (state == CLOSE) || (state == DWELL);

endmodule

// File: tb/tb_gear_shift_scheduler.sv
// Bench for gear_shift_scheduler: directed scenarios plus random traffic against a cycle model.
module tb_gear_shift_scheduler;

   localparam int NG = 5, OPN = 4, ENG = 8, CLS = 4, DWL = 32, HY = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b1;
   logic [7:0] speed = 8'd0;
   logic [1:0] mode = 2'b10;
   logic       kick = 1'b0;
   logic [2:0] gear, state;
   logic       clutch, busy;

   gear_shift_scheduler dut (
      .clk           (clk),
      .rst           (rst),
      .ena           (ena),
      .speed_i       (speed),
      .mode_i        (mode),
      .kickdown_i    (kick),
      .gear_o        (gear),
      .clutch_open_o (clutch),
      .shift_busy_o  (busy),
      .state_o       (state)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: phase name, cycles left in phase (incl. current), gear, target.
   int m_st = 0, m_left = 0, m_gear = 0, m_tgt = 0;

   function automatic int run_target();
      int th[5];
      bit fwd;
      int dn;
      th = '{20, 40, 60, 80, 100};
      fwd = (m_gear >= 1 && m_gear <= NG);
      if ((fwd && mode != 2'b11) || (m_gear == 7 && mode != 2'b01)) return 0;
      if (!fwd) return -1;
      if (kick && m_gear > 1) return m_gear - 1;
      if (m_gear < NG && int'(speed) >= th[m_gear-1]) return m_gear + 1;
      if (m_gear > 1) begin
         dn = th[m_gear-2] - HY;
         if (dn < 0) dn = 0;
         if (int'(speed) < dn) return m_gear - 1;
      end
      return -1;
   endfunction

   function automatic void start(input int t);
      m_tgt  = t;
      m_st   = 2;
      m_left = OPN;
   endfunction

   always @(posedge clk) begin
      int nt;
      if (rst) begin
         m_st = 0; m_left = 0; m_gear = 0; m_tgt = 0;
      end else if (ena) begin
         case (m_st)
            0: if (mode == 2'b11) start(1);
               else if (mode == 2'b01 && speed == 8'd0) start(7);
            1: begin
               nt = run_target();
               if (nt >= 0) start(nt);
            end
            2: if (m_left > 1) m_left--;
               else begin m_gear = m_tgt; m_st = 3; m_left = ENG; end
            3: if (m_left > 1) m_left--;
               else begin m_st = 4; m_left = CLS; end
            4: if (m_left > 1) m_left--;
               else begin m_st = 5; m_left = DWL; end
            5: if (kick && m_gear > 1 && m_gear <= NG) start(m_gear - 1);
               else if (m_left > 1) m_left--;
               else begin m_st = (m_gear == 0) ? 0 : 1; m_left = 0; end
            default: m_st = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_state", int'(state), m_st);
         chk("model_gear", int'(gear), m_gear);
         chk("model_clutch", int'(clutch), int'(m_st == 2 || m_st == 3));
         chk("model_busy", int'(busy), int'(m_st >= 2 && m_st <= 5));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_until(input string nm, input int ws, input int wg, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         tick();
         if (int'(state) == ws && (wg < 0 || int'(gear) == wg)) break;
      end
      if (i == budget) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: timeout waiting for state %0d gear %0d, got state %0d gear %0d",
                  nm, ws, wg, state, gear);
      end
   endtask

   initial begin
      int clutch_cnt, busy_cnt, first_g1, st49, resume;
      // 1. reset
      rst = 1'b1;
      tick();
      cmp_en = 1'b1;
      tick();
      chk("rst_state", int'(state), 0);
      chk("rst_gear", int'(gear), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_clutch", int'(clutch), 0);
      rst = 1'b0;
      tick();
      chk("idle_hold", int'(state), 0);

      // 2. drive from IDLE
      mode = 2'b11; speed = 8'd0;
      clutch_cnt = 0; busy_cnt = 0; first_g1 = -1; st49 = -1;
      for (int k = 1; k <= 52; k++) begin
         tick();
         clutch_cnt += int'(clutch);
         busy_cnt   += int'(busy);
         if (first_g1 < 0 && gear == 3'd1) first_g1 = k;
         if (k == 49) st49 = int'(state);
      end
      chk("drive_clutch_cycles", clutch_cnt, 12);
      chk("drive_gear1_cycle", first_g1, 5);
      chk("drive_busy_cycles", busy_cnt, 48);
      chk("drive_then_run", st49, 1);

      // 3. upshift and hysteresis
      speed = 8'd20;
      wait_until("upshift_2", 1, 2, 200);
      speed = 8'd17;
      repeat (20) tick();
      chk("hyst_no_down_gear", int'(gear), 2);
      chk("hyst_no_down_state", int'(state), 1);
      speed = 8'd15;
      wait_until("downshift_1", 1, 1, 200);
      chk("down_gear", int'(gear), 1);

      // 4. kickdown during DWELL
      speed = 8'd50;
      wait_until("reach_g3_dwell", 5, 3, 400);
      repeat (12) tick();
      chk("dwell_still", int'(state), 5);
      kick = 1'b1;
      tick();
      chk("kick_open", int'(state), 2);
      kick = 1'b0;
      repeat (3) tick();
      chk("kick_gear_before", int'(gear), 3);
      tick();
      chk("kick_gear_after", int'(gear), 2);

      // 5. reverse guard and reset mid-shift
      mode = 2'b10;
      wait_until("to_idle", 0, 0, 400);
      mode = 2'b01; speed = 8'd5;
      repeat (6) tick();
      chk("rev_guard_state", int'(state), 0);
      chk("rev_guard_gear", int'(gear), 0);
      speed = 8'd0;
      wait_until("rev_engage", 3, 7, 50);
      chk("rev_gear", int'(gear), 7);
      rst = 1'b1;
      tick();
      chk("midshift_rst_state", int'(state), 0);
      chk("midshift_rst_gear", int'(gear), 0);
      chk("midshift_rst_clutch", int'(clutch), 0);
      rst = 1'b0; mode = 2'b10;
      tick();

      // 6. ena freeze mid-OPEN
      mode = 2'b11; speed = 8'd0;
      tick();
      tick();
      chk("pre_freeze_state", int'(state), 2);
      ena = 1'b0;
      repeat (10) tick();
      chk("freeze_state", int'(state), 2);
      chk("freeze_gear", int'(gear), 0);
      ena = 1'b1;
      resume = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (gear == 3'd1) begin resume = k; break; end
      end
      chk("resume_cycles", resume, 3);

      // random traffic
      for (int n = 0; n < 4000; n++) begin
         int s;
         rst = ($urandom_range(0, 499) == 0);
         ena = ($urandom_range(0, 9) != 0);
         kick = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
         s = int'(speed) + int'($urandom_range(0, 16)) - 8;
         if ($urandom_range(0, 99) == 0) s = 0;
         if (s < 0) s = 0;
         if (s > 120) s = 120;
         speed = 8'(s);
         tick();
      end
      rst = 1'b0;
      ena = 1'b1;
      tick();

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
